// File: rtl/spi_burst_pkg.sv
// spi_burst_ctrl shared constants: FSM encoding, defaults, command width.
// burst_len() maps the 4-bit cmd_len (0 means 16) to a 5-bit byte count.
package spi_burst_pkg;

  localparam int CMD_LEN_W = 4;
  localparam int REM_W     = CMD_LEN_W + 1;

  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_CS_DLY     = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CS_SETUP  = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_BYTE = 3'd3;
  localparam logic [2:0] ST_CS_HOLD   = 3'd4;

  function automatic logic [REM_W-1:0] burst_len(
    input logic [CMD_LEN_W-1:0] len
  );
    if (len == '0)
      return {1'b1, {CMD_LEN_W{1'b0}}};
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word-fall-through read, async active-high reset.
// Ports: clk, rst, wr/wr_data/full (push side), rd/rd_data/empty (pop side).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_wr;
  logic             do_rd;

  assign full  = (cnt == CNT_MAX);
  assign empty = (cnt == '0);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  // Gated so the output reads 0 out of reset and while empty.
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr)
        wptr <= wptr + PTR_ONE;
      if (do_rd)
        rptr <= rptr + PTR_ONE;
      if (do_wr && !do_rd)
        cnt <= cnt + CNT_ONE;
      else if (do_rd && !do_wr)
        cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// SPI burst controller: frames cmd_len bytes under cs_n over a byte engine.
// Ports: cmd_*, tx_*, rx_*, cs_n, done, eng_*. RX path built only with SPI_BURST_RX_EN.
module spi_burst_ctrl
  import spi_burst_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CS_DLY     = DEF_CS_DLY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CMD_LEN_W-1:0] cmd_len,
  input  logic                 tx_wr,
  input  logic [7:0]           tx_data,
  output logic                 tx_full,
  input  logic                 rx_rd,
  output logic [7:0]           rx_data,
  output logic                 rx_empty,
  output logic                 rx_overflow,
  output logic                 cs_n,
  output logic                 done,
  output logic                 eng_start,
  output logic [7:0]           eng_data_in,
  input  logic                 eng_busy,
  input  logic                 eng_new_data,
  input  logic [7:0]           eng_data_out
);

  localparam logic [3:0]       DLY_LAST = 4'(CS_DLY - 1);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  logic [2:0]       state;
  logic [3:0]       dly_cnt;
  logic [REM_W-1:0] rem;
  logic             tx_empty;
  logic [7:0]       tx_head;
  logic             accept;
  logic             issue;
  logic             byte_in;
  logic             dly_last;

  assign cmd_ready = (state == ST_IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign issue     = (state == ST_ISSUE) & ~tx_empty & ~eng_busy;
  assign byte_in   = (state == ST_WAIT_BYTE) & eng_new_data;
  assign dly_last  = (dly_cnt == DLY_LAST);

  assign eng_start   = issue;
  assign eng_data_in = tx_head;
  assign done        = (state == ST_CS_HOLD) & dly_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      dly_cnt <= '0;
      rem     <= '0;
      cs_n    <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            rem     <= burst_len(cmd_len);
            dly_cnt <= '0;
            cs_n    <= 1'b0;
            state   <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (dly_last)
            state <= ST_ISSUE;
          else
            dly_cnt <= dly_cnt + 4'd1;
        end
        ST_ISSUE: begin
          if (issue)
            state <= ST_WAIT_BYTE;
        end
        ST_WAIT_BYTE: begin
          if (eng_new_data) begin
            rem <= rem - REM_ONE;
            if (rem == REM_ONE) begin
              dly_cnt <= '0;
              state   <= ST_CS_HOLD;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_CS_HOLD: begin
          if (dly_last) begin
            cs_n  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            dly_cnt <= dly_cnt + 4'd1;
          end
        end
        default: begin
          cs_n  <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (tx_wr),
    .wr_data (tx_data),
    .full    (tx_full),
    .rd      (issue),
    .rd_data (tx_head),
    .empty   (tx_empty)
  );

`ifdef SPI_BURST_RX_EN
  logic rx_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (byte_in),
    .wr_data (eng_data_out),
    .full    (rx_full),
    .rd      (rx_rd),
    .rd_data (rx_data),
    .empty   (rx_empty)
  );

  // Dropped only when no same-cycle pop makes room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rx_overflow <= 1'b0;
    else if (accept)
      rx_overflow <= 1'b0;
    else if (byte_in && rx_full && !rx_rd)
      rx_overflow <= 1'b1;
  end
`else
  logic unused_rx;

  assign unused_rx   = ^{rx_rd, byte_in, eng_data_out};
  assign rx_data     = '0;
  assign rx_empty    = 1'b1;
  assign rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Self-checking bench for spi_burst_ctrl with a behavioural byte engine.
// Expectations adapt to whether SPI_BURST_RX_EN is defined.
module tb_spi_burst_ctrl;

  localparam int DEPTH = 4;
  localparam int DLY   = 2;
`ifdef SPI_BURST_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_len;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_overflow;
  logic       cs_n;
  logic       done;
  logic       eng_start;
  logic [7:0] eng_data_in;
  logic       eng_busy;
  logic       eng_new_data;
  logic [7:0] eng_data_out;

  spi_burst_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .CS_DLY     (DLY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .tx_wr        (tx_wr),
    .tx_data      (tx_data),
    .tx_full      (tx_full),
    .rx_rd        (rx_rd),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_overflow  (rx_overflow),
    .cs_n         (cs_n),
    .done         (done),
    .eng_start    (eng_start),
    .eng_data_in  (eng_data_in),
    .eng_busy     (eng_busy),
    .eng_new_data (eng_new_data),
    .eng_data_out (eng_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: what was written, what went out, what rx should hold.
  logic [7:0] exp_tx[$];
  logic [7:0] start_q[$];
  logic [7:0] exp_rx[$];
  bit   model_ovf = 1'b0;
  bit   rx_seen   = 1'b0;
  int   start_cnt = 0;
  int   done_cnt  = 0;
  int   cs_fall_cyc = 0;
  int   first_start_cyc = -1;
  int   last_nd_cyc = 0;
  int   done_cyc = 0;
  logic prev_cs_n = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_cs_n && !cs_n) begin
        cs_fall_cyc = cyc;
        first_start_cyc = -1;
        model_ovf = 1'b0;
      end
      if (eng_start) begin
        start_cnt++;
        start_q.push_back(eng_data_in);
        if (first_start_cyc < 0) first_start_cyc = cyc;
      end
      if (eng_new_data && !cs_n) begin
        last_nd_cyc = cyc;
        if (RX_EN) begin
          if (exp_rx.size() < DEPTH) exp_rx.push_back(eng_data_out);
          else model_ovf = 1'b1;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!rx_empty) rx_seen = 1'b1;
    end
    prev_cs_n = cs_n;
  end

  // Byte engine: busy for a random 1..4 cycles, then returns a random byte.
  initial begin
    eng_busy = 1'b0;
    eng_new_data = 1'b0;
    eng_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (eng_start && !rst) begin
        @(posedge clk); #1;
        eng_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        eng_busy = 1'b0;
        eng_new_data = 1'b1;
        eng_data_out = 8'($urandom);
        @(posedge clk); #1;
        eng_new_data = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 1000 && tx_full; g++) tick();
      b = 8'($urandom);
      exp_tx.push_back(b);
      tx_wr = 1'b1;
      tx_data = b;
      tick();
      tx_wr = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    for (int n = 0; n < budget && done_cnt == d0; n++) tick();
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s done: got no pulse in %0d cycles, want 1 pulse",
               tag, budget);
    end
  endtask

  task automatic check_tx(input string tag);
    int idx = -1;
    checks++;
    if (start_q.size() == exp_tx.size())
      foreach (exp_tx[i])
        if (idx < 0 && start_q[i] !== exp_tx[i]) idx = i;
    if (start_q.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL %s tx count: got %0d starts, want %0d",
               tag, start_q.size(), exp_tx.size());
    end else if (idx >= 0) begin
      errors++;
      $display("FAIL %s tx byte %0d: got %02h, want %02h",
               tag, idx, start_q[idx], exp_tx[idx]);
    end
    start_q.delete();
    exp_tx.delete();
  endtask

  task automatic drain_rx(input string tag);
    while (exp_rx.size() > 0) begin
      checks++;
      if (rx_empty !== 1'b0 || rx_data !== exp_rx[0]) begin
        errors++;
        $display("FAIL %s rx: got empty=%0b data=%02h, want empty=0 data=%02h",
                 tag, rx_empty, rx_data, exp_rx[0]);
      end
      rx_rd = 1'b1;
      tick();
      rx_rd = 1'b0;
      void'(exp_rx.pop_front());
    end
    checks++;
    if (rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL %s rx drained: got empty=%0b, want 1", tag, rx_empty);
    end
  endtask

  task automatic check_ovf(input string tag);
    checks++;
    if (rx_overflow !== model_ovf) begin
      errors++;
      $display("FAIL %s overflow: got %0b, want %0b",
               tag, rx_overflow, model_ovf);
    end
  endtask

  task automatic check_done_count(input int d0, input int want, input string tag);
    checks++;
    if (done_cnt - d0 != want) begin
      errors++;
      $display("FAIL %s done count: got %0d, want %0d",
               tag, done_cnt - d0, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({cs_n, cmd_ready, done, eng_start} !== 4'b1000) begin
      errors++;
      $display("FAIL reset ctrl: got cs_n/rdy/done/start=%04b, want 1000",
               {cs_n, cmd_ready, done, eng_start});
    end
    checks++;
    if ({tx_full, rx_empty, rx_overflow} !== 3'b010 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset fifo: got full/empty/ovf=%03b data=%02h, want 010 00",
               {tx_full, rx_empty, rx_overflow}, rx_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset release: got cmd_ready=%0b, want 1", cmd_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h3C);
    tx_wr = 1'b1; tx_data = 8'hA5; tick();
    tx_data = 8'h3C; tick();
    tx_wr = 1'b0;
    rx_seen = 1'b0;
    send_cmd(4'd2);
    wait_done(200, "basic");
    repeat (3) tick();
    checks++;
    if (first_start_cyc - cs_fall_cyc != DLY) begin
      errors++;
      $display("FAIL basic setup: got %0d cycles, want %0d",
               first_start_cyc - cs_fall_cyc, DLY);
    end
    checks++;
    if (done_cyc - last_nd_cyc != DLY) begin
      errors++;
      $display("FAIL basic hold: got %0d cycles, want %0d",
               done_cyc - last_nd_cyc, DLY);
    end
    check_tx("basic");
    check_done_count(d0, 1, "basic");
    checks++;
    if (rx_seen !== RX_EN) begin
      errors++;
      $display("FAIL basic rx activity: got %0b, want %0b", rx_seen, RX_EN);
    end
    check_ovf("basic");
    drain_rx("basic");
  endtask

  task automatic test_stall();
    int d0 = done_cnt;
    int s0 = start_cnt;
    feed(1);
    send_cmd(4'd3);
    cmd_valid = 1'b1;
    cmd_len = 4'd5;
    repeat (50) tick();
    checks++;
    if (cs_n !== 1'b0 || eng_start !== 1'b0 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL stall: got cs_n=%0b start=%0b starts=%0d, want 0 0 1",
               cs_n, eng_start, start_cnt - s0);
    end
    check_done_count(d0, 0, "stall early");
    cmd_valid = 1'b0;
    feed(2);
    wait_done(200, "stall");
    repeat (5) tick();
    check_tx("stall");
    check_done_count(d0, 1, "stall");
    checks++;
    if (cs_n !== 1'b1) begin
      errors++;
      $display("FAIL stall no queued cmd: got cs_n=%0b, want 1", cs_n);
    end
    drain_rx("stall");
  endtask

  task automatic test_overflow();
    send_cmd(4'd6);
    fork
      feed(6);
      wait_done(300, "ovf");
    join
    tick();
    check_tx("ovf");
    check_ovf("ovf");
    drain_rx("ovf");
    check_ovf("ovf sticky");
    send_cmd(4'd1);
    checks++;
    if (rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf clear: got %0b, want 0", rx_overflow);
    end
    feed(1);
    wait_done(100, "ovf next");
    tick();
    check_tx("ovf next");
    drain_rx("ovf next");
  endtask

  task automatic test_len16();
    int d0 = done_cnt;
    int s0 = start_cnt;
    send_cmd(4'd0);
    fork
      feed(16);
      wait_done(600, "len16");
    join
    repeat (3) tick();
    checks++;
    if (start_cnt - s0 != 16) begin
      errors++;
      $display("FAIL len16 starts: got %0d, want 16", start_cnt - s0);
    end
    check_tx("len16");
    check_done_count(d0, 1, "len16");
    check_ovf("len16");
    drain_rx("len16");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len = $urandom_range(0, 15);
      int n = (len == 0) ? 16 : len;
      int pre = $urandom_range(0, (n < DEPTH) ? n : DEPTH);
      int d0 = done_cnt;
      feed(pre);
      send_cmd(4'(len));
      fork
        feed(n - pre);
        wait_done(600, "random");
      join
      repeat (2) tick();
      check_tx("random");
      check_done_count(d0, 1, "random");
      check_ovf("random");
      drain_rx("random");
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    int s0 = start_cnt;
    feed(4);
    send_cmd(4'd2);
    for (int g = 0; g < 100 && start_cnt == s0; g++) tick();
    feed(1);
    checks++;
    if (tx_full !== 1'b1 || cs_n !== 1'b0) begin
      errors++;
      $display("FAIL midrst setup: got full=%0b cs_n=%0b, want 1 0",
               tx_full, cs_n);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({cs_n, tx_full, rx_empty, done, rx_overflow} !== 5'b10100) begin
      errors++;
      $display("FAIL midrst: got cs_n/full/empty/done/ovf=%05b, want 10100",
               {cs_n, tx_full, rx_empty, done, rx_overflow});
    end
    exp_tx.delete();
    start_q.delete();
    exp_rx.delete();
    model_ovf = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check_done_count(d0, 0, "midrst");
    checks++;
    if (cs_n !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst idle: got cs_n=%0b rdy=%0b, want 1 1",
               cs_n, cmd_ready);
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_len = 4'd0;
    tx_wr = 1'b0;
    tx_data = 8'h00;
    rx_rd = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_len16();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at %0t, want finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
